// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router: stores {header marker, byte}
// words and tracks the remaining length of the packet being read out.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-low
//   soft_reset  synchronous flush, active-high
//   write_enb   write strobe
//   read_enb    read strobe
//   lfd_state   1 = byte being written is a packet header
//   data_in     byte to store
//   data_out    registered read data
//   full        no free entries
//   empty       no stored entries
//   pkt_active  a packet read is in progress
module router_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  read_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  pkt_active
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [DATA_WIDTH:0]   mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [6:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH:0]   rd_word;
    logic                  do_wr, do_rd;

    // Flags come straight from the registered pointers, so a simultaneous
    // read/write sees the occupancy from before the edge.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

    assign do_wr = write_enb && !full && !soft_reset;
    assign do_rd = read_enb && !empty && !soft_reset;

    assign rd_word    = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign data_out   = dout_q;
    assign pkt_active = (cnt_q != 7'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        if (soft_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            dout_d   = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                dout_d   = rd_word[DATA_WIDTH-1:0];
                // Header reloads with payload length plus the parity byte;
                // a header mid-packet abandons the truncated packet.
                if (rd_word[DATA_WIDTH]) begin
                    cnt_d = 7'(rd_word[7:2]) + 7'd1;
                end else if (cnt_q != 7'd0) begin
                    cnt_d = cnt_q - 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {lfd_state, data_in};
        end
    end

endmodule
